tia_poly_audio: RTL and testbench

Parametrised multi-channel polynomial audio generator for the Atari 2600 TIA model. Each channel combines a programmable frequency divider, a mode-selected LFSR or tone flip-flop, and a volume register; a registered mixer sums all channels. It sits behind the TIA register-write decoder and feeds the audio DAC/PWM stage, driven by a once-per-audio-sample clock enable.

---
 rtl/tia_audio_pkg.sv | 28 ++
 rtl/tia_poly_audio_if.sv | 15 +
 rtl/tia_audio_voice.sv | 91 +++++++++
 rtl/tia_poly_audio.sv | 61 ++++++
 tb/tb_tia_poly_audio.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tia_audio_pkg.sv
// Shared constants and helpers for the TIA polynomial audio block.
// Register addresses, the constant-mode code and the per-channel mode decode.
package tia_audio_pkg;

    localparam logic [1:0] ADDR_AUDC = 2'd0;
    localparam logic [1:0] ADDR_AUDF = 2'd1;
    localparam logic [1:0] ADDR_AUDV = 2'd2;

    localparam logic [3:0] MODE_CONST = 4'd0;

    typedef enum logic [1:0] {
        CH_CONST = 2'd0,
        CH_LFSR  = 2'd1,
        CH_TONE  = 2'd2
    } ch_mode_e;

    // AUDC values past the last usable LFSR tap fall back to a square tone.
    function automatic ch_mode_e decode_mode(input logic [3:0] audc, input int lfsr_w);
        if (audc == MODE_CONST) begin
            return CH_CONST;
        end else if (int'(audc) < lfsr_w) begin
            return CH_LFSR;
        end else begin
            return CH_TONE;
        end
    endfunction

endpackage

// File: rtl/tia_poly_audio_if.sv
// Register-write bus from the TIA write decoder into the audio block.
interface tia_poly_audio_if #(
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            wr_en;
    logic [CH_W-1:0] wr_ch;
    logic [1:0]      wr_addr;
    logic [7:0]      wr_data;

    modport master (output wr_en, wr_ch, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_ch, wr_addr, wr_data);

endinterface

// File: rtl/tia_audio_voice.sv
// One audio channel: AUDC/AUDF/AUDV registers, tick divider, LFSR, tone flip-flop
// and the volume-gated output level.
module tia_audio_voice
    import tia_audio_pkg::*;
#(
    parameter int LFSR_W = 9,
    parameter int DIV_W  = 5,
    parameter int VOL_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_en,
    input  logic             wr_sel,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic             ch_bit,
    output logic [VOL_W-1:0] ch_level
);

    logic [3:0]        audc;
    logic [DIV_W-1:0]  audf;
    logic [VOL_W-1:0]  audv;
    logic [DIV_W-1:0]  cnt;
    logic [LFSR_W-1:0] sr;
    logic              tone_ff;
    logic              step;
    logic              tap;
    ch_mode_e          mode;

    // Upper data bits are simply not part of these narrow registers.
    logic unused_data;
    assign unused_data = ^wr_data;

    assign mode = decode_mode(audc, LFSR_W);
    assign step = tick_en && (cnt >= audf);

    always_comb begin
        tap = 1'b0;
        for (int i = 1; i < LFSR_W; i++) begin
            if (audc == 4'(i)) tap = sr[i];
        end
    end

    // Divider counts ticks; a stale count above a newly written AUDF wraps on the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick_en) begin
            cnt <= step ? '0 : cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= LFSR_W'(1);
            tone_ff <= 1'b0;
        end else if (step) begin
            case (mode)
                CH_LFSR: sr <= (sr == '0) ? LFSR_W'(1) : {tap ^ sr[0], sr[LFSR_W-1:1]};
                CH_TONE: tone_ff <= ~tone_ff;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audc <= '0;
            audf <= '0;
            audv <= '0;
        end else if (wr_sel) begin
            case (wr_addr)
                ADDR_AUDC: audc <= wr_data[3:0];
                ADDR_AUDF: audf <= wr_data[DIV_W-1:0];
                ADDR_AUDV: audv <= wr_data[VOL_W-1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        case (mode)
            CH_LFSR: ch_bit = sr[0];
            CH_TONE: ch_bit = tone_ff;
            default: ch_bit = 1'b1;
        endcase
    end

    assign ch_level = ch_bit ? audv : '0;

endmodule

// File: rtl/tia_poly_audio.sv
// Multi-channel TIA polynomial audio generator: per-channel voices, write decode
// and a registered sum of all channel levels for the DAC/PWM stage.
module tia_poly_audio
    import tia_audio_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int LFSR_W = 9,
    parameter int DIV_W  = 5,
    parameter int VOL_W  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 tick_en,
    tia_poly_audio_if.slave                      bus,
    output logic [NUM_CH-1:0]                    ch_bit,
    output logic [NUM_CH*VOL_W-1:0]              ch_level,
    output logic [VOL_W+$clog2(NUM_CH)-1:0]      mix_out
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MIX_W = VOL_W + $clog2(NUM_CH);

    logic [MIX_W-1:0] mix_sum;

    // Out-of-range channel numbers match no voice, so those writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
        logic wr_sel;
        assign wr_sel = bus.wr_en && (bus.wr_ch == CH_W'(i));

        tia_audio_voice #(
            .LFSR_W (LFSR_W),
            .DIV_W  (DIV_W),
            .VOL_W  (VOL_W)
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_en  (tick_en),
            .wr_sel   (wr_sel),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .ch_bit   (ch_bit[i]),
            .ch_level (ch_level[i*VOL_W +: VOL_W])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_sum = mix_sum + MIX_W'(ch_level[i*VOL_W +: VOL_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_out <= '0;
        end else begin
            mix_out <= mix_sum;
        end
    end

endmodule

// File: tb/tb_tia_poly_audio.sv
// Scoreboard bench for tia_poly_audio: a plain-arithmetic channel model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_tia_poly_audio;

    localparam int NUM_CH = 3;
    localparam int LFSR_W = 9;
    localparam int DIV_W  = 5;
    localparam int VOL_W  = 4;
    localparam int MIX_W  = VOL_W + $clog2(NUM_CH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_en = 1'b0;
    logic [NUM_CH-1:0]       ch_bit;
    logic [NUM_CH*VOL_W-1:0] ch_level;
    logic [MIX_W-1:0]        mix_out;

    tia_poly_audio_if #(.NUM_CH(NUM_CH)) bus();

    tia_poly_audio #(
        .NUM_CH (NUM_CH),
        .LFSR_W (LFSR_W),
        .DIV_W  (DIV_W),
        .VOL_W  (VOL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_en  (tick_en),
        .bus      (bus),
        .ch_bit   (ch_bit),
        .ch_level (ch_level),
        .mix_out  (mix_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]       bits;
        logic [NUM_CH*VOL_W-1:0] lvl;
        logic [MIX_W-1:0]        mix;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    int m_audc[NUM_CH];
    int m_audf[NUM_CH];
    int m_audv[NUM_CH];
    int m_cnt[NUM_CH];
    int m_sr[NUM_CH];
    int m_tone[NUM_CH];
    int m_mix;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_bit(input int c);
        if (m_audc[c] == 0) return 1;
        if (m_audc[c] < LFSR_W) return m_sr[c] & 1;
        return m_tone[c];
    endfunction

    function automatic int m_level(input int c);
        return (m_bit(c) != 0) ? m_audv[c] : 0;
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_audc[c] = 0; m_audf[c] = 0; m_audv[c] = 0;
            m_cnt[c] = 0;  m_sr[c] = 1;   m_tone[c] = 0;
        end
        m_mix = 0;
    endfunction

    function automatic void m_step(input int c);
        int fb;
        if (m_audc[c] == 0) return;
        if (m_audc[c] < LFSR_W) begin
            if (m_sr[c] == 0) begin
                m_sr[c] = 1;
            end else begin
                fb = (m_sr[c] ^ (m_sr[c] >> m_audc[c])) & 1;
                m_sr[c] = (m_sr[c] >> 1) | (fb << (LFSR_W - 1));
            end
        end else begin
            m_tone[c] = m_tone[c] ^ 1;
        end
    endfunction

    // Model of one rising edge given the inputs currently applied.
    function automatic void m_edge();
        int sum = 0;
        int ch, addr, data;
        for (int c = 0; c < NUM_CH; c++) sum += m_level(c);
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_mix = sum;
        if (tick_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_cnt[c] >= m_audf[c]) begin
                    m_cnt[c] = 0;
                    m_step(c);
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
        end
        if (bus.wr_en) begin
            ch = int'(bus.wr_ch);
            addr = int'(bus.wr_addr);
            data = int'(bus.wr_data);
            if (ch < NUM_CH) begin
                case (addr)
                    0: m_audc[ch] = data % 16;
                    1: m_audf[ch] = data % (1 << DIV_W);
                    2: m_audv[ch] = data % (1 << VOL_W);
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            e.bits[c] = (m_bit(c) != 0);
            e.lvl[c*VOL_W +: VOL_W] = VOL_W'(m_level(c));
        end
        e.mix = MIX_W'(m_mix);
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_edge();
        sb.push_back(make_exp());
        #1;
    endtask

    task automatic wr(input int ch, input int addr, input int data, input bit tk = 1'b0);
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'(ch);
        bus.wr_addr = 2'(addr);
        bus.wr_data = 8'(data);
        tick_en = tk;
        cyc();
        bus.wr_en = 1'b0;
        tick_en = 1'b0;
    endtask

    task automatic idle(input int n, input bit tk);
        tick_en = tk;
        repeat (n) cyc();
        tick_en = 1'b0;
    endtask

    // Asserts reset between edges, after the monitor has consumed the last entry.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_ch_bit", 64'(ch_bit), 64'({NUM_CH{1'b1}}));
        chk("async_ch_level", 64'(ch_level), 64'd0);
        chk("async_mix", 64'(mix_out), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ch_bit", 64'(ch_bit), 64'(e.bits));
            chk("ch_level", 64'(ch_level), 64'(e.lvl));
            chk("mix_out", 64'(mix_out), 64'(e.mix));
        end
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_ch = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        m_reset();
        repeat (2) cyc();
        rst_n = 1'b1;

        // LFSR taps at bit 4, stepping every tick
        wr(0, 0, 4);
        wr(0, 1, 0);
        wr(0, 2, 15);
        idle(10, 1'b1);

        // Divider period 4 ticks with tick on every other clock, then AUDF shrink at cnt=3
        wr(0, 1, 3);
        repeat (12) begin
            idle(1, 1'b1);
            idle(1, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            if (m_cnt[0] == 3) break;
            idle(1, 1'b1);
            idle(1, 1'b0);
        end
        chk("div_cnt_at_3", 64'(m_cnt[0]), 64'd3);
        wr(0, 1, 1);
        repeat (8) begin
            idle(1, 1'b1);
            idle(1, 1'b0);
        end

        // Tone on channel 1
        wr(1, 0, 15);
        wr(1, 1, 0);
        wr(1, 2, 9);
        idle(6, 1'b1);

        // Mixer
        wr(0, 0, 0);
        wr(1, 0, 0);
        wr(0, 2, 15);
        wr(1, 2, 15);
        idle(3, 1'b0);
        chk("mix_30", 64'(mix_out), 64'd30);
        wr(1, 2, 7);
        idle(3, 1'b0);
        chk("mix_22", 64'(mix_out), 64'd22);

        // Ignored writes
        wr(0, 3, 'hFF);
        wr(3, 0, 'hFF);
        wr(3, 2, 'hFF);
        wr(3, 1, 'hFF);
        idle(2, 1'b1);
        chk("filter_mix", 64'(mix_out), 64'd22);

        // Write coincident with tick uses old AUDF
        wr(0, 0, 15);
        wr(0, 1, 0);
        wr(0, 1, 5, 1'b1);
        idle(14, 1'b1);

        async_reset();
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'd0;
        bus.wr_addr = 2'd2;
        bus.wr_data = 8'hFF;
        idle(2, 1'b1);
        bus.wr_en = 1'b0;
        rst_n = 1'b1;
        idle(2, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                async_reset();
                idle(2, 1'b1);
                rst_n = 1'b1;
            end
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.wr_ch = 2'($urandom_range(0, 3));
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            tick_en = ($urandom_range(0, 2) != 0);
            cyc();
        end
        bus.wr_en = 1'b0;
        idle(2, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
